// File: rtl/objects_pkg.sv
// Shared types and constants for the object drawing / pixel arbitration path.
package objects_pkg;

  localparam int RGB_W = 8;
  localparam logic [RGB_W-1:0] TRANSPARENT_COLOR = 8'hFF;

  typedef logic [2:0] layer_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/layer_priority_table.sv
// Shadow/active priority tables: host writes land in the shadow copy, and a commit
// promotes it only if it is a valid permutation, otherwise the shadow is rolled back.
module layer_priority_table
  import objects_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       wr_en,
  input  layer_id_t                  wr_slot,
  input  layer_id_t                  wr_layer,
  input  logic                       commit,
  output layer_id_t [NUM_LAYERS-1:0] active_table,
  output logic                       commit_error
);

  layer_id_t shadow_reg [NUM_LAYERS];
  layer_id_t active_reg [NUM_LAYERS];

  logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] match;
  logic [NUM_LAYERS-1:0]                 present;
  logic                                  perm_ok;
  logic                                  wr_ok;

  // Shadow entries are always in range, so "every layer present" implies each exactly once.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    for (genvar gj = 0; gj < NUM_LAYERS; gj++) begin : g_slot
      assign match[gi][gj] = (shadow_reg[gj] == layer_id_t'(gi));
    end
    assign present[gi]      = |match[gi];
    assign active_table[gi] = active_reg[gi];
  end

  assign perm_ok = &present;
  assign wr_ok   = wr_en && (int'(wr_slot) < NUM_LAYERS) && (int'(wr_layer) < NUM_LAYERS);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < NUM_LAYERS; s++) begin
        shadow_reg[s] <= layer_id_t'(s);
        active_reg[s] <= layer_id_t'(s);
      end
      commit_error <= 1'b0;
    end else if (commit) begin
      for (int s = 0; s < NUM_LAYERS; s++) begin
        if (perm_ok) active_reg[s] <= shadow_reg[s];
        else         shadow_reg[s] <= active_reg[s];
      end
      commit_error <= !perm_ok;
    end else if (wr_ok) begin
      for (int s = 0; s < NUM_LAYERS; s++) begin
        if (wr_slot == layer_id_t'(s)) shadow_reg[s] <= wr_layer;
      end
    end
  end

endmodule

// File: rtl/layer_priority_scheduler.sv
// Frame-synchronous priority arbiter between object layers and background, with a
// two-stage pixel pipeline, per-frame collision flags and a tear-free table update FSM.
module layer_priority_scheduler
  import objects_pkg::*;
#(
  parameter int               NUM_LAYERS  = 4,
  parameter int               RGB_W       = objects_pkg::RGB_W,
  parameter logic [RGB_W-1:0] TRANSPARENT = objects_pkg::TRANSPARENT_COLOR
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic                        cfgWrite,
  input  logic [2:0]                  cfgSlot,
  input  logic [2:0]                  cfgLayer,
  output logic                        cfgReady,
  output logic                        cfgError,
  output logic [RGB_W-1:0]            pixelRGB,
  output logic [2:0]                  pixelLayerId,
  output logic [NUM_LAYERS-1:0]       collisionMask
);

  localparam layer_id_t LAYER_BG = layer_id_t'(NUM_LAYERS);

  cfg_state_t state_reg, state_next;
  logic       wr_en;
  logic       commit;

  layer_id_t [NUM_LAYERS-1:0] active_table;

  logic [NUM_LAYERS-1:0]       hit_next;
  logic [NUM_LAYERS-1:0]       hit_reg;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_reg;
  logic [RGB_W-1:0]            bg_reg;
  logic                        multi_hit;
  logic [NUM_LAYERS-1:0]       acc_reg;
  logic [NUM_LAYERS-1:0]       frame_hits;

  logic [RGB_W-1:0] win_rgb;
  layer_id_t        win_id;

  assign cfgReady = (state_reg != COMMIT);
  assign wr_en    = cfgWrite && cfgReady;
  assign commit   = (state_reg == COMMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wr_en) state_next = PENDING;
      PENDING: if (startOfFrame) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  layer_priority_table #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_table (
    .clk         (clk),
    .resetN      (resetN),
    .wr_en       (wr_en),
    .wr_slot     (cfgSlot),
    .wr_layer    (cfgLayer),
    .commit      (commit),
    .active_table(active_table),
    .commit_error(cfgError)
  );

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
    assign hit_next[gi] = layerDrawingRequest[gi] &&
                          (layerRGB[gi*RGB_W +: RGB_W] != TRANSPARENT);
  end

  // Two or more simultaneous hits on one pixel counts as an overlap.
  assign multi_hit  = |(hit_next & (hit_next - {{(NUM_LAYERS-1){1'b0}}, 1'b1}));
  assign frame_hits = multi_hit ? hit_next : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_reg       <= '0;
      rgb_reg       <= '0;
      bg_reg        <= '0;
      acc_reg       <= '0;
      collisionMask <= '0;
    end else begin
      hit_reg <= hit_next;
      rgb_reg <= layerRGB;
      bg_reg  <= backGroundRGB;
      if (startOfFrame) begin
        collisionMask <= acc_reg | frame_hits;
        acc_reg       <= '0;
      end else begin
        acc_reg <= acc_reg | frame_hits;
      end
    end
  end

  // Walk slots from lowest to highest priority so slot 0 is applied last and wins.
  always_comb begin
    win_rgb = bg_reg;
    win_id  = LAYER_BG;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (active_table[s] == layer_id_t'(l) && hit_reg[l]) begin
          win_rgb = rgb_reg[l*RGB_W +: RGB_W];
          win_id  = layer_id_t'(l);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelRGB     <= '0;
      pixelLayerId <= LAYER_BG;
    end else begin
      pixelRGB     <= win_rgb;
      pixelLayerId <= win_id;
    end
  end

endmodule
